// File: rtl/inst_encoder_loader.sv
// Instruction encoder and loader: packs decoded field bundles into 16-bit
// instruction words and writes them to consecutive instruction memory
// addresses, rejecting opcodes the decoder does not implement.
module inst_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs,
    input  logic [3:0]        in_rt,
    input  logic              in_last,
    output logic              imem_wen,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic [3:0]        err_op,
    output logic              full,
    output logic              done
);

    // Highest implemented opcode (BEQ); everything above it is illegal.
    localparam logic [3:0]        OP_MAX    = 4'b1010;
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                last_reg, last_next;
    logic [ADDR_W:0]     count_reg, count_next;
    logic                err_reg, err_next;
    logic [3:0]          err_op_reg, err_op_next;
    logic                full_reg, full_next;
    logic                done_reg, done_next;
    logic                wen_reg, wen_next;
    logic [ADDR_W-1:0]   waddr_reg, waddr_next;
    logic [15:0]         wdata_reg, wdata_next;

    logic                op_legal;
    logic [15:0]         word_packed;

    assign op_legal    = (in_op <= OP_MAX);
    // Field placement is identical for every legal opcode.
    assign word_packed = {in_op, in_rd, in_rs, in_rt};

    // State and registered outputs; reset aborts any write in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            addr_reg   <= '0;
            last_reg   <= 1'b0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
            err_op_reg <= 4'd0;
            full_reg   <= 1'b0;
            done_reg   <= 1'b0;
            wen_reg    <= 1'b0;
            waddr_reg  <= '0;
            wdata_reg  <= 16'd0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            last_reg   <= last_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
            err_op_reg <= err_op_next;
            full_reg   <= full_next;
            done_reg   <= done_next;
            wen_reg    <= wen_next;
            waddr_reg  <= waddr_next;
            wdata_reg  <= wdata_next;
        end
    end

    // Next-state and next-output decode; write port holds its last value
    // whenever no write is issued.
    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        last_next   = last_reg;
        count_next  = count_reg;
        err_next    = err_reg;
        err_op_next = err_op_reg;
        full_next   = full_reg;
        done_next   = done_reg;
        wen_next    = 1'b0;
        waddr_next  = waddr_reg;
        wdata_next  = wdata_reg;
        in_ready    = (state_reg == S_LOAD);

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next  = S_LOAD;
                    addr_next   = FIRST_ADDR;
                    count_next  = '0;
                    err_next    = 1'b0;
                    err_op_next = 4'd0;
                    full_next   = 1'b0;
                    done_next   = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (op_legal) begin
                        last_next  = in_last;
                        wen_next   = 1'b1;
                        waddr_next = addr_reg;
                        wdata_next = word_packed;
                        state_next = S_WRITE;
                    end else begin
                        // Only the first rejected opcode of a session is kept.
                        err_next = 1'b1;
                        if (!err_reg) begin
                            err_op_next = in_op;
                        end
                        if (in_last) begin
                            done_next  = 1'b1;
                            state_next = S_DONE;
                        end
                    end
                end
            end
            S_WRITE: begin
                count_next = count_reg + 1'b1;
                addr_next  = addr_reg + 1'b1;
                // Running out of space ends the session even mid-program.
                if (addr_reg == LAST_ADDR) begin
                    full_next  = 1'b1;
                    done_next  = 1'b1;
                    state_next = S_DONE;
                end else if (last_reg) begin
                    done_next  = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign imem_wen   = wen_reg;
    assign imem_addr  = waddr_reg;
    assign imem_wdata = wdata_reg;
    assign count      = count_reg;
    assign err        = err_reg;
    assign err_op     = err_op_reg;
    assign full       = full_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench for inst_encoder_loader: a default-size instance (A) and
// a four-word instance (B). Expected writes are queued by stimulus; monitors
// pop and compare on every imem_wen.
module tb_inst_encoder_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_op = 4'd0, in_rd = 4'd0, in_rs = 4'd0, in_rt = 4'd0;
    logic       in_last  = 1'b0;
    logic       sel      = 1'b0;   // 0: drive instance A, 1: drive instance B

    // Instance A (defaults)
    logic        rdy_a, wen_a, err_a, full_a, done_a;
    logic [7:0]  addr_a;
    logic [15:0] wdata_a;
    logic [8:0]  count_a;
    logic [3:0]  err_op_a;

    // Instance B (four words)
    logic        rdy_b, wen_b, err_b, full_b, done_b;
    logic [1:0]  addr_b;
    logic [15:0] wdata_b;
    logic [2:0]  count_b;
    logic [3:0]  err_op_b;

    inst_encoder_loader u_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .in_valid(in_valid & ~sel),
        .in_ready(rdy_a), .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_last(in_last), .imem_wen(wen_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .count(count_a), .err(err_a), .err_op(err_op_a), .full(full_a), .done(done_a)
    );

    inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0), .DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .in_valid(in_valid & sel),
        .in_ready(rdy_b), .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_last(in_last), .imem_wen(wen_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .count(count_b), .err(err_b), .err_op(err_op_b), .full(full_b), .done(done_b)
    );

    int tests  = 0;
    int failed = 0;

    logic [23:0] exp_a[$];   // {addr, data}
    logic [23:0] exp_b[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endfunction

    // Monitors: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wen_a) begin
            logic [23:0] e;
            tests++;
            if (exp_a.size() == 0) begin
                failed++;
                $display("FAIL write_a: unexpected write 0x%04h @0x%02h", wdata_a, addr_a);
            end else begin
                e = exp_a.pop_front();
                if ({addr_a, wdata_a} !== e) begin
                    failed++;
                    $display("FAIL write_a: got 0x%04h @0x%02h, expected 0x%04h @0x%02h",
                             wdata_a, addr_a, e[15:0], e[23:16]);
                end else begin
                    $display("[TB] ok   write_a 0x%04h @0x%02h", wdata_a, addr_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (wen_b) begin
            logic [23:0] e;
            tests++;
            if (exp_b.size() == 0) begin
                failed++;
                $display("FAIL write_b: unexpected write 0x%04h @0x%0h", wdata_b, addr_b);
            end else begin
                e = exp_b.pop_front();
                if ({6'd0, addr_b, wdata_b} !== e) begin
                    failed++;
                    $display("FAIL write_b: got 0x%04h @0x%0h, expected 0x%04h @0x%0h",
                             wdata_b, addr_b, e[15:0], e[23:16]);
                end else begin
                    $display("[TB] ok   write_b 0x%04h @0x%0h", wdata_b, addr_b);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one bundle to the selected instance; returns on the negedge after
    // the accepting edge. wr=1 queues the hand-computed write.
    task automatic send(input logic [3:0] op, rd, rs, rt, input logic last,
                        input logic wr, input logic [7:0] ea, input logic [15:0] ed);
        bit got = 0;
        in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if ((sel ? rdy_b : rdy_a) === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            tests++;
            failed++;
            $display("FAIL accept_timeout: op 0x%0h not accepted, expected accept", op);
            in_valid = 1'b0;
        end else begin
            if (wr) begin
                if (sel) exp_b.push_back({ea, ed});
                else     exp_a.push_back({ea, ed});
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        #12;
        check("reset_ready_a", rdy_a, 0);
        check("reset_wen_a",   wen_a, 0);
        check("reset_flags_a", {count_a, err_a, err_op_a, full_a, done_a}, 0);
        check("reset_outs_b",  {rdy_b, wen_b, count_b, err_b, full_b, done_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD rd=3 rs=1 rt=2: ready drops for the write cycle, then back in LOAD
        do_start();
        check("load_ready", rdy_a, 1);
        send(4'h0, 4'd3, 4'd1, 4'd2, 1'b0, 1'b1, 8'h00, 16'h0312);
        check("write_cycle_ready", rdy_a, 0);
        @(negedge clk);
        check("after_add_ready", rdy_a, 1);
        check("after_add_count", count_a, 1);
        check("after_add_done",  done_a, 0);

        // SW then BEQ(last) in a fresh session
        do_reset();
        do_start();
        send(4'h9, 4'd5, 4'd2, 4'd4, 1'b0, 1'b1, 8'h00, 16'h9524);
        send(4'hA, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 8'h01, 16'hA123);
        @(negedge clk);
        check("prog_count", count_a, 2);
        check("prog_done",  done_a, 1);
        check("prog_ready", rdy_a, 0);
        // in_valid in DONE must be ignored (monitor flags any write)
        in_op = 4'h0; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("done_ignores_valid_count", count_a, 2);

        // Illegal opcodes only
        do_reset();
        do_start();
        send(4'hC, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00, 16'h0000);
        check("illegal_err_early", err_a, 1);
        send(4'hF, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 8'h00, 16'h0000);
        check("illegal_err",    err_a, 1);
        check("illegal_err_op", err_op_a, 4'hC);
        check("illegal_count",  count_a, 0);
        check("illegal_done",   done_a, 1);

        // DONE then start: fresh session, writes restart at base
        do_start();
        check("restart_flags", {count_a, err_a, err_op_a, full_a, done_a}, 0);
        send(4'h0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 8'h00, 16'h0123);
        @(negedge clk);
        check("restart_count", count_a, 1);
        check("restart_done",  done_a, 1);

        // Reset asserted during the write cycle
        do_reset();
        do_start();
        in_op = 4'h2; in_rd = 4'd7; in_rs = 4'd6; in_rt = 4'd5; in_last = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("midwrite_wen_before", wen_a, 1);
        rst_n = 1'b0;
        #1;
        check("midwrite_wen_after", wen_a, 0);
        check("midwrite_flags", {rdy_a, count_a, err_a, err_op_a, full_a, done_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midwrite_idle_ready", rdy_a, 0);

        // Four-word instance fills up; a fifth bundle is never accepted
        sel = 1'b1;
        do_start();
        send(4'h1, 4'd1, 4'd0, 4'd0, 1'b0, 1'b1, 8'h00, 16'h1100);
        send(4'h3, 4'd2, 4'd0, 4'd1, 1'b0, 1'b1, 8'h01, 16'h3201);
        send(4'h5, 4'd3, 4'd4, 4'd2, 1'b0, 1'b1, 8'h02, 16'h5342);
        send(4'h8, 4'd4, 4'd5, 4'd6, 1'b0, 1'b1, 8'h03, 16'h8456);
        @(negedge clk);
        check("full_b",  full_b, 1);
        check("done_b",  done_b, 1);
        check("count_b", count_b, 4);
        begin
            logic seen_ready = 1'b0;
            in_op = 4'h7; in_last = 1'b0; in_valid = 1'b1;
            repeat (6) begin
                @(negedge clk);
                if (rdy_b) seen_ready = 1'b1;
            end
            in_valid = 1'b0;
            check("fifth_not_accepted", seen_ready, 0);
        end
        sel = 1'b0;

        repeat (2) @(negedge clk);
        check("pending_writes_a", exp_a.size(), 0);
        check("pending_writes_b", exp_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Sequential instruction encoder and loader, the counterpart to the opcode decoder in the control path.
- Accepts decoded instruction fields (opcode, register and immediate fields) over a valid/ready handshake and packs them into 16-bit instruction words.
- Rejects opcodes the decoder does not implement.
- Writes each legal word into instruction memory at consecutive addresses, so programs can be loaded from a testbench or host.

Parameters:
ADDR_W, 8, instruction memory address width
BASE_ADDR, 0, first address written after start
DEPTH, 256, number of writable words from BASE_ADDR; BASE_ADDR+DEPTH <= 2^ADDR_W

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous assert, active low
start  input  1  one-cycle pulse that begins a load session
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle this cycle
in_op  input  4  opcode
in_rd  input  4  destination register (second source for SW/BEQ)
in_rs  input  4  first source register
in_rt  input  4  second source register, shift amount (SLL/SRL) or offset (LW/SW/BEQ)
in_last  input  1  bundle is the final instruction of the program
imem_wen  output  1  instruction memory write enable
imem_addr  output  ADDR_W  write address
imem_wdata  output  16  encoded instruction word
count  output  ADDR_W+1  number of words written this session
err  output  1  sticky: an illegal opcode was rejected this session
err_op  output  4  opcode of the first rejected bundle
full  output  1  the last writable address was used
done  output  1  session finished

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset: all outputs are 0 and state is IDLE. Reset mid-write aborts the write; imem_wen drops immediately.
- Opcodes:
  - ADD=0000, SUB=0001, AND=0010, XOR=0011, COM=0100, SLL=0101, SRL=0110, MUL=0111, LW=1000, SW=1001, BEQ=1010.
  - 1011..1111 are illegal.
- Encoding: word = {in_op, in_rd, in_rs, in_rt}. Field placement is the same for every legal opcode; field meaning per opcode is as listed under Ports.
- Registered outputs: imem_wen, imem_addr, imem_wdata, count, err, err_op, full, done. in_ready is decoded from state.
- State IDLE: in_ready=0. start -> LOAD; on that edge addr=BASE_ADDR, count=0, err=0, err_op=0, full=0, done=0.
- State LOAD: in_ready=1. Accept occurs when in_valid && in_ready.
  - Legal op: latch the word and in_last, go to WRITE.
  - Illegal op: no write.
    - err=1; err_op is captured only if err was 0.
    - If in_last -> DONE, else stay in LOAD.
- State WRITE (exactly one cycle): in_ready=0, imem_wen=1, imem_addr=addr, imem_wdata=latched word.
  - On exit: count+=1 and addr+=1.
  - If addr==BASE_ADDR+DEPTH-1: full=1, go to DONE. This takes priority over in_last.
  - Else if latched last: go to DONE.
  - Else: go to LOAD.
- State DONE: done=1, in_ready=0.
  - start -> LOAD with the same initialisation as from IDLE.
  - in_valid is ignored.
- Timing:
  - Latency from accept edge to imem_wen high is 1 cycle.
  - Maximum throughput is one bundle every 2 cycles.
- start is ignored in LOAD and WRITE.
- imem_addr and imem_wdata hold their last values when imem_wen=0.
- No wrap-around: once full is set, no further writes occur until the next start.

Test Plan:
- Reset, start, ADD rd=3 rs=1 rt=2 with in_last=0 -> in_ready drops for one cycle; next cycle imem_wen=1, addr=0x00, wdata=0x0312; count=1; back in LOAD.
- Bundles SW rd=5 rs=2 off=4, then BEQ rd=1 rs=2 off=3 with last=1 -> writes 0x9524@0x00 and 0xA123@0x01; count=2, done=1, in_ready=0; further in_valid is ignored.
- Illegal op 1100, then 1111 with last=1 -> no imem_wen; err=1, err_op=0xC, count=0, done=1.
- ADDR_W=2, DEPTH=4: five legal bundles with last=0 -> four writes at addresses 0..3; full=1, done=1 after the 4th write; fifth bundle is never accepted.
- rst_n asserted low in the WRITE cycle -> imem_wen, count and all flags go to 0 asynchronously; state is IDLE; in_ready=0 until the next start.
- DONE then start -> addr restarts at BASE_ADDR, count=0, err=0; next ADD writes at 0x00.
